// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI4-Lite master engine.
package axil_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R,
        S_DONE
    } axil_state_e;

    localparam logic AXIL_OK = 1'b1;

    function automatic int unsigned beats(input int unsigned width, input int unsigned dsz);
        return width / dsz;
    endfunction

endpackage

// File: rtl/axil_master_engine.sv
// AXI4-Lite master: streams NUM_OPS operands out as DSZ-bit write beats, reads back an RES_SZ-bit result.
// Optional macro RESP_RETRY_EN reissues a failed beat up to MAX_RETRY times before flagging err.
module axil_master_engine
    import axil_pkg::*;
#(
    parameter int unsigned SZ        = 32,
    parameter int unsigned NUM_OPS   = 2,
    parameter int unsigned RES_SZ    = 64,
    parameter int unsigned DSZ       = 8,
    parameter int unsigned ASZ       = 4,
    parameter int unsigned WBASE     = 0,
    parameter int unsigned RBASE     = 0,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_OPS*SZ-1:0] op_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [RES_SZ-1:0]     res,
    output logic [ASZ-1:0]        awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DSZ-1:0]        wdata,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic                  bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ASZ-1:0]        araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DSZ-1:0]        rdata,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic                  rresp
);

    localparam int unsigned OPW  = NUM_OPS * SZ;
    localparam int unsigned WB   = beats(OPW, DSZ);
    localparam int unsigned RB   = beats(RES_SZ, DSZ);
    localparam int unsigned KMAX = (WB > RB) ? WB : RB;
    localparam int unsigned KW   = (KMAX > 1) ? $clog2(KMAX) : 1;
    localparam int unsigned RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
`ifdef RESP_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    axil_state_e       state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [OPW-1:0]    shadow_q, shadow_d;
    logic [RES_SZ-1:0] res_sh_q, res_sh_d;
    logic [RES_SZ-1:0] res_q, res_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [ASZ-1:0]    awaddr_q, awaddr_d;
    logic              awvalid_q, awvalid_d;
    logic [DSZ-1:0]    wdata_q, wdata_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic [ASZ-1:0]    araddr_q, araddr_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;

    // Next-state, counters and the registered channel outputs derived from the next state.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        retry_d  = retry_q;
        shadow_d = shadow_q;
        res_sh_d = res_sh_q;
        res_d    = res_q;
        err_d    = err_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shadow_d = op_data;
                    err_d    = 1'b0;
                    k_d      = '0;
                    retry_d  = '0;
                    state_d  = S_AW;
                end
            end
            S_AW: if (awvalid_q && awready) state_d = S_W;
            S_W:  if (wvalid_q && wready)   state_d = S_B;
            S_B: begin
                if (bvalid && bready_q) begin
                    if (RETRY_EN && (bresp != AXIL_OK) && (retry_q < RW'(MAX_RETRY))) begin
                        retry_d = retry_q + RW'(1);
                        state_d = S_AW;
                    end else begin
                        if (bresp != AXIL_OK) err_d = 1'b1;
                        retry_d = '0;
                        if (k_q == KW'(WB - 1)) begin
                            k_d     = '0;
                            state_d = S_AR;
                        end else begin
                            k_d     = k_q + KW'(1);
                            state_d = S_AW;
                        end
                    end
                end
            end
            S_AR: if (arvalid_q && arready) state_d = S_R;
            S_R: begin
                if (rvalid && rready_q) begin
                    for (int unsigned i = 0; i < RB; i++) begin
                        if (k_q == KW'(i)) res_sh_d[i*DSZ +: DSZ] = rdata;
                    end
                    if (RETRY_EN && (rresp != AXIL_OK) && (retry_q < RW'(MAX_RETRY))) begin
                        retry_d = retry_q + RW'(1);
                        state_d = S_AR;
                    end else begin
                        if (rresp != AXIL_OK) err_d = 1'b1;
                        retry_d = '0;
                        if (k_q == KW'(RB - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            k_d     = k_q + KW'(1);
                            state_d = S_AR;
                        end
                    end
                end
            end
            S_DONE: begin
                res_d   = res_sh_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Address/data track k, which only moves on a completed response, so they hold while valid is up.
        busy_d    = (state_d != S_IDLE);
        awvalid_d = (state_d == S_AW);
        wvalid_d  = (state_d == S_W);
        bready_d  = (state_d == S_B);
        arvalid_d = (state_d == S_AR);
        rready_d  = (state_d == S_R);
        awaddr_d  = ASZ'(WBASE) + ASZ'(k_d);
        araddr_d  = ASZ'(RBASE) + ASZ'(k_d);
        wdata_d   = '0;
        for (int unsigned i = 0; i < WB; i++) begin
            if (k_d == KW'(i)) wdata_d = shadow_d[i*DSZ +: DSZ];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            retry_q   <= '0;
            shadow_q  <= '0;
            res_sh_q  <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            awaddr_q  <= '0;
            awvalid_q <= 1'b0;
            wdata_q   <= '0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            retry_q   <= retry_d;
            shadow_q  <= shadow_d;
            res_sh_q  <= res_sh_d;
            res_q     <= res_d;
            err_q     <= err_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            awaddr_q  <= awaddr_d;
            awvalid_q <= awvalid_d;
            wdata_q   <= wdata_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign res     = res_q;
    assign awaddr  = awaddr_q;
    assign awvalid = awvalid_q;
    assign wdata   = wdata_q;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;
    assign araddr  = araddr_q;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

endmodule

// File: tb/tb_axil_master_engine.sv
// Self-checking bench for axil_master_engine with a scripted AXI4-Lite slave and a transaction-level model.
module tb_axil_master_engine;

    localparam int DSZ       = 8;
    localparam int ASZ       = 4;
    localparam int WB        = 8;
    localparam int RB        = 8;
    localparam int MAX_RETRY = 3;
    localparam int WBASE     = 0;
    localparam int RBASE     = 0;
`ifdef RESP_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [63:0]    op_data;
    logic           busy, done, err;
    logic [63:0]    res;
    logic [ASZ-1:0] awaddr, araddr;
    logic           awvalid, awready, wvalid, wready, bresp, bvalid, bready;
    logic           arvalid, arready, rvalid, rready, rresp;
    logic [DSZ-1:0] wdata, rdata;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    axil_master_engine dut (
        .clk(clk), .rst(rst), .start(start), .op_data(op_data),
        .busy(busy), .done(done), .err(err), .res(res),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready), .rresp(rresp)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected transaction stream for the current command.
    int          exp_aw[$];
    int          exp_w[$];
    int          exp_ar[$];
    logic [63:0] exp_res;
    logic        exp_err;
    int          exp_lat;

    // Slave knobs: which address stalls / fails and how many times.
    int stall_addr = -1, stall_left = 0;
    int bfail_addr = -1, bfail_left = 0;
    int rfail_addr = -1, rfail_left = 0;
    int last_aw = 0, last_ar = 0;

    // Always-ready slave answering B/R in the same cycle the master is ready.
    always @(negedge clk) begin
        if (awvalid && int'(awaddr) == stall_addr && stall_left > 0) begin
            awready = 1'b0;
            stall_left--;
        end else begin
            awready = 1'b1;
        end
        if (awvalid && awready) last_aw = int'(awaddr);
        wready = 1'b1;
        bvalid = bready;
        bresp  = 1'b1;
        if (bready && last_aw == bfail_addr && bfail_left > 0) begin
            bresp = 1'b0;
            bfail_left--;
        end
        arready = 1'b1;
        if (arvalid) last_ar = int'(araddr);
        rvalid = rready;
        rdata  = DSZ'(last_ar - RBASE + 1);
        rresp  = 1'b1;
        if (rready && last_ar == rfail_addr && rfail_left > 0) begin
            rresp = 1'b0;
            rfail_left--;
        end
    end

    // Compare process: checks every handshake and every done pulse against the model.
    bit             aw_wait = 1'b0;
    logic [ASZ-1:0] aw_hold;
    int             n_done = 0;
    logic [7:0]     obs_w[$];

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (aw_wait) begin
                check("aw_hold_valid", 64'(awvalid), 64'd1);
                check("aw_hold_addr", 64'(awaddr), 64'(aw_hold));
            end
            aw_wait = awvalid && !awready;
            aw_hold = awaddr;
            if (awvalid && awready) begin
                if (exp_aw.size() == 0) check("aw_extra", 64'd1, 64'd0);
                else check("awaddr", 64'(awaddr), 64'(exp_aw.pop_front()));
                check("busy_aw", 64'(busy), 64'd1);
            end
            if (wvalid && wready) begin
                obs_w.push_back(wdata);
                if (exp_w.size() == 0) check("w_extra", 64'd1, 64'd0);
                else check("wdata", 64'(wdata), 64'(exp_w.pop_front()));
            end
            if (arvalid && arready) begin
                if (exp_ar.size() == 0) check("ar_extra", 64'd1, 64'd0);
                else check("araddr", 64'(araddr), 64'(exp_ar.pop_front()));
            end
            if (done) begin
                n_done++;
                check("res", res, exp_res);
                check("err_done", 64'(err), 64'(exp_err));
                check("busy_done", 64'(busy), 64'd0);
                check("beats_left", 64'(exp_aw.size() + exp_w.size() + exp_ar.size()), 64'd0);
            end
        end
    end

    function automatic int attempts(input int fails);
        if (!RETRY) return 1;
        return (fails + 1 < MAX_RETRY + 1) ? fails + 1 : MAX_RETRY + 1;
    endfunction

    task automatic build_model(input logic [63:0] op, input int wfb, input int wfn,
                               input int rfb, input int rfn, input int stall);
        int wa, ra;
        exp_aw.delete(); exp_w.delete(); exp_ar.delete();
        wa = attempts(wfn);
        ra = attempts(rfn);
        for (int b = 0; b < WB; b++) begin
            for (int n = 0; n < ((b == wfb) ? wa : 1); n++) begin
                exp_aw.push_back(WBASE + b);
                exp_w.push_back(int'((op >> (8 * b)) & 64'hFF));
            end
        end
        exp_res = '0;
        for (int b = 0; b < RB; b++) begin
            for (int n = 0; n < ((b == rfb) ? ra : 1); n++) exp_ar.push_back(RBASE + b);
            exp_res = exp_res | (64'(b + 1) << (8 * b));
        end
        exp_err = RETRY ? (wfn > MAX_RETRY || rfn > MAX_RETRY) : (wfn > 0 || rfn > 0);
        exp_lat = 3 * WB + 2 * RB + 1 + stall + 3 * (wa - 1) + 2 * (ra - 1);
        stall_addr = WBASE + 2; stall_left = stall;
        bfail_addr = WBASE + wfb; bfail_left = wfn;
        rfail_addr = RBASE + rfb; rfail_left = rfn;
    endtask

    task automatic issue_start(input logic [63:0] op, output int t0);
        @(negedge clk);
        op_data = op;
        start   = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        check("busy_after_start", 64'(busy), 64'd1);
        check("err_cleared", 64'(err), 64'd0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int t0, output int lat);
        bit seen = 1'b0;
        lat = -1;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            #2;
            if (done) begin
                seen = 1'b1;
                lat  = cyc - t0;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
    endtask

    task automatic run(input logic [63:0] op, input int wfb, input int wfn,
                       input int rfb, input int rfn, input int stall, output int lat);
        int t0;
        build_model(op, wfb, wfn, rfb, rfn, stall);
        obs_w.delete();
        issue_start(op, t0);
        wait_done(t0, lat);
        check("latency", 64'(lat), 64'(exp_lat));
        repeat (2) @(negedge clk);
        #2;
        check("err_sticky", 64'(err), 64'(exp_err));
        check("done_pulse_low", 64'(done), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, t0, d0;
        bit hit;
        rst = 1'b1; start = 1'b0; op_data = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 1'b1;
        arready = 1'b0; rvalid = 1'b0; rresp = 1'b1; rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
        check("rst_flags", 64'({busy, done, err}), 64'd0);
        check("rst_res", res, 64'd0);
        check("rst_addr", 64'({awaddr, araddr}), 64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Ideal slave, operands 0x12345678 / 0x9ABCDEF0.
        run(64'h9ABC_DEF0_1234_5678, -1, 0, -1, 0, 0, lat);
        check("lit_res", res, 64'h0807_0605_0403_0201);
        check("lit_lat", 64'(lat), 64'd41);
        check("lit_err", 64'(err), 64'd0);
        if (obs_w.size() == 8) begin
            check("lit_w0", 64'(obs_w[0]), 64'h78);
            check("lit_w3", 64'(obs_w[3]), 64'h12);
            check("lit_w4", 64'(obs_w[4]), 64'hF0);
            check("lit_w7", 64'(obs_w[7]), 64'h9A);
        end else begin
            check("w_count", 64'(obs_w.size()), 64'd8);
        end

        // awready low for 2 cycles on beat 2.
        run(64'h9ABC_DEF0_1234_5678, -1, 0, -1, 0, 2, lat);
        check("lit_lat_stall", 64'(lat), 64'd43);

        // bresp=0 on beat 3: once, twice, four times.
        run(64'h9ABC_DEF0_1234_5678, 3, 1, -1, 0, 0, lat);
        check("lit_err_b1", 64'(err), RETRY ? 64'd0 : 64'd1);
        check("lit_lat_b1", 64'(lat), RETRY ? 64'd44 : 64'd41);
        check("lit_res_b1", res, 64'h0807_0605_0403_0201);
        run(64'h9ABC_DEF0_1234_5678, 3, 2, -1, 0, 0, lat);
        check("lit_lat_b2", 64'(lat), RETRY ? 64'd47 : 64'd41);
        run(64'h9ABC_DEF0_1234_5678, 3, 4, -1, 0, 0, lat);
        check("lit_err_b4", 64'(err), 64'd1);
        check("lit_lat_b4", 64'(lat), RETRY ? 64'd50 : 64'd41);

        // rresp=0 on read beat 5, then a clean command with other operands.
        run(64'h0011_2233_4455_6677, -1, 0, 5, 1, 0, lat);
        run(64'h0000_0001_FFFF_FFFF, -1, 0, -1, 0, 0, lat);

        // start pulsed while in R must be ignored.
        build_model(64'hCAFE_F00D_DEAD_BEEF, -1, 0, -1, 0, 0);
        d0 = n_done;
        issue_start(64'hCAFE_F00D_DEAD_BEEF, t0);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            #2;
            if (rready) hit = 1'b1;
        end
        check("saw_rready", 64'(hit), 64'd1);
        op_data = 64'h1111_1111_1111_1111;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(t0, lat);
        check("latency_busy_start", 64'(lat), 64'd41);
        repeat (30) @(negedge clk);
        #2;
        check("single_done", 64'(n_done - d0), 64'd1);
        check("idle_after", 64'(busy), 64'd0);

        // Reset in the middle of W aborts everything.
        build_model(64'h9ABC_DEF0_1234_5678, -1, 0, -1, 0, 0);
        issue_start(64'h9ABC_DEF0_1234_5678, t0);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            #2;
            if (wvalid) hit = 1'b1;
        end
        check("saw_wvalid", 64'(hit), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_res", res, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run(64'h9ABC_DEF0_1234_5678, -1, 0, -1, 0, 0, lat);
        check("lit_lat_after_rst", 64'(lat), 64'd41);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
